// File: rtl/rv32im_dmem_ctrl_pkg.sv
// Shared definitions for the rv32im data-memory bus controller: data width,
// 2-bit FSM state encodings, LSU mask constants and the byte-enable helper.
package rv32im_dmem_ctrl_pkg;

  localparam int API_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'b00,
    DMEM_ST_REQ  = 2'b01,
    DMEM_ST_RESP = 2'b10,
    DMEM_ST_DONE = 2'b11
  } dmem_state_e;

  localparam logic [3:0] LSU_MASK_LOAD = 4'b0000;
  localparam logic [3:0] LSU_MASK_WORD = 4'b1111;

  // Loads always fetch the whole word; stores use the LSU's lane mask.
  function automatic logic [3:0] dmem_bus_be(input logic [3:0] wr_mask);
    return (wr_mask != LSU_MASK_LOAD) ? wr_mask : LSU_MASK_WORD;
  endfunction

endpackage

// File: rtl/rv32im_dmem_ctrl_timeout.sv
// Transaction watchdog for rv32im_dmem_ctrl: counts cycles spent in REQ/RESP and
// flags expiry. Only compiled when DMEM_TIMEOUT_EN is defined.
`ifdef DMEM_TIMEOUT_EN
module rv32im_dmem_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter restarts whenever the controller is outside REQ/RESP.
  assign cnt_d     = run_i ? (cnt_q + CW'(1)) : '0;
  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/rv32im_dmem_ctrl.sv
// Data-memory bus controller between rv32im_lsu and a req/gnt + rvalid bus.
// Optional watchdog abort is enabled with the DMEM_TIMEOUT_EN macro.
module rv32im_dmem_ctrl
  import rv32im_dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      lsu_enable_i,
  input  logic [API_DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [API_DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [3:0]                lsu_wr_mask_i,
  output logic [API_DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                      stall_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [3:0]                bus_be_o,
  output logic [API_DATA_WIDTH-1:0] bus_addr_o,
  output logic [API_DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                      bus_gnt_i,
  input  logic                      bus_rvalid_i,
  input  logic [API_DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                      bus_err_i,
  output logic [1:0]                dbg_state_o
);

  dmem_state_e               state_q, state_d;
  logic [API_DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [3:0]                be_q;
  logic                      we_q, err_q;
  logic                      complete_w, timeout_w;
  logic [1:0]                addr_lsb_unused;

  // Byte offset is already folded into the LSU's lane mask.
  assign addr_lsb_unused = lsu_addr_i[1:0];

  // A response is only taken once the address phase has been granted.
  assign complete_w = bus_rvalid_i &&
                      ((state_q == DMEM_ST_RESP) || (state_q == DMEM_ST_REQ && bus_gnt_i));

`ifdef DMEM_TIMEOUT_EN
  rv32im_dmem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .run_i    ((state_q == DMEM_ST_REQ) || (state_q == DMEM_ST_RESP)),
    .expired_o(timeout_w)
  );
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= DMEM_ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMEM_ST_IDLE: if (lsu_enable_i) state_d = DMEM_ST_REQ;
      DMEM_ST_REQ: begin
        if (complete_w || timeout_w) state_d = DMEM_ST_DONE;
        else if (bus_gnt_i)          state_d = DMEM_ST_RESP;
      end
      DMEM_ST_RESP: if (complete_w || timeout_w) state_d = DMEM_ST_DONE;
      DMEM_ST_DONE: state_d = DMEM_ST_IDLE;
      default:      state_d = DMEM_ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req_o = (state_q == DMEM_ST_REQ);
    done_o    = (state_q == DMEM_ST_DONE);
    stall_o   = lsu_enable_i && (state_q != DMEM_ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == DMEM_ST_IDLE && lsu_enable_i) begin
        addr_q  <= {lsu_addr_i[API_DATA_WIDTH-1:2], 2'b00};
        wdata_q <= lsu_wdata_i;
        be_q    <= dmem_bus_be(lsu_wr_mask_i);
        we_q    <= (lsu_wr_mask_i != LSU_MASK_LOAD);
      end
      // Completion wins over a coincident watchdog expiry.
      if (complete_w) begin
        err_q <= bus_err_i;
        if (!we_q) rdata_q <= bus_rdata_i;
      end else if (timeout_w) begin
        err_q <= 1'b1;
      end else if (state_q == DMEM_ST_DONE) begin
        err_q <= 1'b0;
      end
    end
  end

  assign lsu_rdata_o = rdata_q;
  assign err_o       = err_q;
  assign bus_we_o    = we_q;
  assign bus_be_o    = be_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// Bench for rv32im_dmem_ctrl: directed vector table, hand sequences for reset,
// watchdog (DMEM_TIMEOUT_EN) and back-to-back, then random accesses vs a model.
module tb_rv32im_dmem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        lsu_enable_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [3:0]  lsu_wr_mask_i;
  logic [31:0] lsu_rdata_o;
  logic        stall_o, done_o, err_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;
  logic [1:0]  dbg_state_o;

  rv32im_dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .lsu_enable_i(lsu_enable_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wr_mask_i(lsu_wr_mask_i), .lsu_rdata_o(lsu_rdata_o),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .bus_err_i(bus_err_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = '0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          g;      // extra REQ cycles before gnt
    int          r;      // cycles from gnt to rvalid (0 = same cycle)
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic        exp_we;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_bus();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
    bus_rdata_i  = $urandom();
  endtask

  task automatic do_reset();
    rst_n_i      = 1'b0;
    lsu_enable_i = 1'b0;
    clear_bus();
    cyc();
    cyc();
    rst_n_i     = 1'b1;
    model_rdata = '0;
  endtask

  // Idle cycle with a stray rvalid that must be ignored.
  task automatic idle_gap();
    lsu_enable_i = 1'b0;
    bus_rvalid_i = 1'($urandom_range(0, 1));
    bus_rdata_i  = $urandom();
    cyc();
    chk("idle_done", done_o, 0);
    chk("idle_req", bus_req_o, 0);
    chk("idle_stall", stall_o, 0);
    chk("idle_rdata", lsu_rdata_o, model_rdata);
    clear_bus();
  endtask

  // Driver + bus responder for one access; enable asserted at cycle 0.
  task automatic do_access(input vec_t v, input bit spur);
    bit done_seen = 0;
    int done_c = 2 + v.g + v.r;
    exp_q.push_back(v.exp_we ? model_rdata : v.rdata);
    lsu_enable_i  = 1'b1;
    lsu_addr_i    = v.addr;
    lsu_wr_mask_i = v.mask;
    lsu_wdata_i   = v.wdata;
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      cyc();
      clear_bus();
      chk("req", bus_req_o, (c <= 1 + v.g) ? 1 : 0);
      chk("done", done_o, (c == done_c) ? 1 : 0);
      chk("stall", stall_o, (c == done_c) ? 0 : 1);
      if (bus_req_o) begin
        chk("bus_addr", bus_addr_o, v.exp_baddr);
        chk("bus_be", bus_be_o, v.exp_be);
        chk("bus_we", bus_we_o, v.exp_we);
        if (v.exp_we) chk("bus_wdata", bus_wdata_o, v.wdata);
      end
      if (done_o) begin
        done_seen = 1;
        model_rdata = exp_q.pop_front();
        chk("err", err_o, v.err);
        chk("rdata", lsu_rdata_o, model_rdata);
        lsu_enable_i = 1'b0;
      end else begin
        chk("rdata_hold", lsu_rdata_o, model_rdata);
      end
      if (c == 1 + v.g) begin
        bus_gnt_i = 1'b1;
        if (v.r == 0) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = v.rdata;
          bus_err_i    = v.err;
        end
      end else if (v.r > 0 && c == 1 + v.g + v.r) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = v.rdata;
        bus_err_i    = v.err;
      end else if (spur && c <= v.g) begin
        bus_rvalid_i = 1'b1;
        bus_err_i    = 1'($urandom_range(0, 1));
      end
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL access_timeout actual=no_done required=done_at_cycle_%0d", done_c);
      lsu_enable_i = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  // Reference: expected bus fields straight from the address/mask rules.
  function automatic vec_t rand_vec();
    vec_t v;
    v.addr      = $urandom();
    v.mask      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    v.wdata     = $urandom();
    v.g         = $urandom_range(0, 3);
    v.r         = $urandom_range(0, 3);
    v.rdata     = $urandom();
    v.err       = ($urandom_range(0, 7) == 0);
    v.exp_baddr = v.addr - (v.addr % 4);
    v.exp_we    = (v.mask != 0);
    v.exp_be    = v.exp_we ? v.mask : 4'hF;
    return v;
  endfunction

  initial begin
    vecs[0] = '{32'h0000_0006, 4'h0, 32'h0,         0, 0, 32'h0843_9341, 1'b0, 32'h0000_0004, 4'hF, 1'b0};
    vecs[1] = '{32'h0000_0005, 4'h2, 32'h0000_4100, 2, 2, 32'hDEAD_BEEF, 1'b0, 32'h0000_0004, 4'h2, 1'b1};
    vecs[2] = '{32'h0000_0100, 4'h0, 32'h0,         1, 1, 32'h1234_5678, 1'b1, 32'h0000_0100, 4'hF, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 4'hF, 32'hA5A5_5A5A, 0, 3, 32'h0,         1'b0, 32'hFFFF_FFFC, 4'hF, 1'b1};
    vecs[4] = '{32'h8000_0002, 4'hC, 32'h7777_0000, 3, 0, 32'h0,         1'b1, 32'h8000_0000, 4'hC, 1'b1};
    vecs[5] = '{32'h0000_0013, 4'h0, 32'h0,         0, 1, 32'hCAFE_F00D, 1'b0, 32'h0000_0010, 4'hF, 1'b0};

    lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wr_mask_i = '0;
    do_reset();
    chk("rst_req", bus_req_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", lsu_rdata_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_be", bus_be_o, 0);

    // directed vectors
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i], (i % 2) == 1);
      idle_gap();
    end

    // reset while in RESP aborts without done
    lsu_enable_i = 1'b1; lsu_addr_i = 32'h40; lsu_wr_mask_i = 4'h0;
    cyc(); clear_bus(); bus_gnt_i = 1'b1;
    cyc(); clear_bus();
    chk("resp_req", bus_req_o, 0);
    chk("resp_stall", stall_o, 1);
    #2;
    rst_n_i = 1'b0; lsu_enable_i = 1'b0;
    #1;
    chk("arst_req", bus_req_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_we", bus_we_o, 0);
    chk("arst_addr", bus_addr_o, 0);
    chk("arst_rdata", lsu_rdata_o, 0);
    model_rdata = '0;
    cyc();
    rst_n_i = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    for (int c = 0; c < 4; c++) begin
      cyc();
      clear_bus();
      chk("post_rst_done", done_o, 0);
      chk("post_rst_req", bus_req_o, 0);
      chk("post_rst_rdata", lsu_rdata_o, 0);
    end

    // grant never arrives
    lsu_enable_i = 1'b1; lsu_addr_i = 32'h20; lsu_wr_mask_i = 4'h0;
`ifdef DMEM_TIMEOUT_EN
    for (int c = 1; c <= 6; c++) begin
      cyc();
      chk("to_req", bus_req_o, (c <= 4) ? 1 : 0);
      chk("to_done", done_o, (c == 5) ? 1 : 0);
      if (c == 5) begin
        chk("to_err", err_o, 1);
        chk("to_rdata", lsu_rdata_o, model_rdata);
        lsu_enable_i = 1'b0;
      end
    end
`else
    for (int c = 1; c <= 20; c++) begin
      cyc();
      chk("wait_req", bus_req_o, 1);
      chk("wait_stall", stall_o, 1);
      chk("wait_done", done_o, 0);
    end
`endif
    do_reset();

    // back-to-back loads with enable held
    lsu_enable_i = 1'b1; lsu_addr_i = 32'h0; lsu_wr_mask_i = 4'h0;
    cyc();
    chk("b2b_req0", bus_req_o, 1);
    chk("b2b_addr0", bus_addr_o, 32'h0);
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1111_0000;
    cyc(); clear_bus();
    chk("b2b_done0", done_o, 1);
    chk("b2b_rdata0", lsu_rdata_o, 32'h1111_0000);
    lsu_addr_i = 32'h4;
    cyc();
    chk("b2b_gap_done", done_o, 0);
    chk("b2b_gap_req", bus_req_o, 0);
    chk("b2b_gap_stall", stall_o, 1);
    cyc();
    chk("b2b_req1", bus_req_o, 1);
    chk("b2b_addr1", bus_addr_o, 32'h4);
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h2222_0004;
    cyc(); clear_bus();
    chk("b2b_done1", done_o, 1);
    chk("b2b_rdata1", lsu_rdata_o, 32'h2222_0004);
    model_rdata = 32'h2222_0004;
    lsu_enable_i = 1'b0;
    cyc();
    chk("b2b_after", done_o, 0);

    // random accesses against the model
    for (int n = 0; n < 40; n++) begin
      do_access(rand_vec(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_gap();
      else begin
        cyc();
        chk("rand_gap_done", done_o, 0);
      end
    end
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
